// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame strobe scheduler.
package frame_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDrain
  } state_e;

  // A programmed period of 0 stands for the full counter range.
  function automatic int unsigned frame_len(input int unsigned period, input int unsigned cnt_w);
    return (period == 0) ? (32'd1 << cnt_w) : period;
  endfunction

endpackage

// File: rtl/frame_strobe_ctrl_if.sv
// Control/config/request bundle between framing control, consumers and the scheduler.
interface frame_strobe_ctrl_if #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned NREQ  = 4
);
  logic             cfg_we;
  logic [CNT_W-1:0] cfg_period;
  logic [CNT_W-1:0] cfg_width;
  logic             start;
  logic             stop;
  logic [NREQ-1:0]  req;
  logic [NREQ-1:0]  gnt;
  logic             strb;
  logic             frame_start;
  logic             busy;

  modport master (
    output cfg_we, cfg_period, cfg_width, start, stop, req,
    input  gnt, strb, frame_start, busy
  );

  modport slave (
    input  cfg_we, cfg_period, cfg_width, start, stop, req,
    output gnt, strb, frame_start, busy
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: search upward from ptr_i with wrap, report winner+1.
module rr_arbiter #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned PTR_W = 2
) (
  input  logic [NREQ-1:0]  req_i,
  input  logic [PTR_W-1:0] ptr_i,
  input  logic             en_i,
  output logic [NREQ-1:0]  gnt_o,
  output logic [PTR_W-1:0] ptr_o
);

  logic        found;
  int unsigned idx;

  always_comb begin
    gnt_o = '0;
    ptr_o = ptr_i;
    found = 1'b0;
    idx   = 0;
    if (en_i) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        idx = (32'(ptr_i) + i) % NREQ;
        if (!found && req_i[PTR_W'(idx)]) begin
          found               = 1'b1;
          gnt_o[PTR_W'(idx)]  = 1'b1;
          ptr_o               = PTR_W'((idx + 1) % NREQ);
        end
      end
    end
  end

endmodule

// File: rtl/frame_strobe_ctrl.sv
// Frame scheduler: run/stop framing with programmable period/width and round-robin frame owner.
module frame_strobe_ctrl
  import frame_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned NREQ       = 4,
  parameter int unsigned DEF_PERIOD = 0,
  parameter int unsigned DEF_WIDTH  = 8
) (
  input logic               clk,
  input logic               rst_n,
  frame_strobe_ctrl_if.slave bus
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [CNT_W-1:0] width_q, width_d;
  logic [CNT_W-1:0] pend_period_q, pend_period_d;
  logic [CNT_W-1:0] pend_width_q, pend_width_d;
  logic [PtrW-1:0]  ptr_q, ptr_d, arb_ptr;
  logic [NREQ-1:0]  gnt_q, gnt_d, arb_gnt;
  logic             strb_q, strb_d;
  logic             fs_q, fs_d;
  logic [CNT_W-1:0] last_cnt;
  logic             at_last;
  logic             boundary;

  assign last_cnt = CNT_W'(frame_len(32'(period_q), CNT_W) - 32'd1);
  assign at_last  = (cnt_q == last_cnt);

  // Stop wins over a wrap, so a stop seen in the last cycle ends framing right there.
  assign boundary = ((state_q == StIdle) && bus.start) ||
                    ((state_q == StRun) && at_last && !bus.stop);

  rr_arbiter #(
    .NREQ (NREQ),
    .PTR_W(PtrW)
  ) u_arb (
    .req_i(bus.req),
    .ptr_i(ptr_q),
    .en_i (boundary),
    .gnt_o(arb_gnt),
    .ptr_o(arb_ptr)
  );

  always_comb begin
    pend_period_d = bus.cfg_we ? bus.cfg_period : pend_period_q;
    pend_width_d  = bus.cfg_we ? bus.cfg_width  : pend_width_q;
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    width_d  = width_q;
    ptr_d    = ptr_q;
    gnt_d    = gnt_q;
    fs_d     = 1'b0;
    strb_d   = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (bus.start) state_d = StRun;
      end
      StRun: begin
        if (at_last && bus.stop) begin
          state_d = StIdle;
        end else if (!at_last) begin
          cnt_d = cnt_q + CNT_W'(1);
          if (bus.stop) state_d = StDrain;
        end
      end
      StDrain: begin
        if (at_last) state_d = StIdle;
        else         cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = StIdle;
    endcase

    // The pending config is sampled before this edge's cfg_we lands, so a write on a
    // boundary edge only takes effect one frame later.
    if (boundary) begin
      cnt_d    = '0;
      period_d = pend_period_q;
      width_d  = pend_width_q;
      gnt_d    = arb_gnt;
      ptr_d    = arb_ptr;
      fs_d     = 1'b1;
    end

    if (state_d == StIdle) begin
      cnt_d = '0;
      gnt_d = '0;
    end else begin
      strb_d = (cnt_d < width_d);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      period_q      <= CNT_W'(DEF_PERIOD);
      width_q       <= CNT_W'(DEF_WIDTH);
      pend_period_q <= CNT_W'(DEF_PERIOD);
      pend_width_q  <= CNT_W'(DEF_WIDTH);
      ptr_q         <= '0;
      gnt_q         <= '0;
      strb_q        <= 1'b0;
      fs_q          <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      width_q       <= width_d;
      pend_period_q <= pend_period_d;
      pend_width_q  <= pend_width_d;
      ptr_q         <= ptr_d;
      gnt_q         <= gnt_d;
      strb_q        <= strb_d;
      fs_q          <= fs_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.strb        = strb_q;
  assign bus.frame_start = fs_q;
  assign bus.busy        = (state_q != StIdle);

endmodule

// File: doc/frame_strobe_ctrl.md
# frame_strobe_ctrl

Programmable scheduler for the long-frame strobe. It replaces the fixed 256-cycle, fixed-width frame counter with run/stop control, programmable frame period and strobe width, and round-robin assignment of each frame to one of NREQ requesters. It sits between the control logic, which starts and stops framing and writes the configuration, and the consumers that gate their work on `strb` and their `gnt` bit.

## Interface
- CNT_W, 8: width of the frame counter and of the config fields.
- NREQ, 4: number of requesters competing for frames.
- DEF_PERIOD, 0: period loaded at reset. 0 means 2^CNT_W cycles.
- DEF_WIDTH, 8: strobe width loaded at reset.

- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- cfg_we  in  1  write enable for cfg_period/cfg_width into the pending registers.
- cfg_period  in  CNT_W  frame length in cycles. 0 means 2^CNT_W.
- cfg_width  in  CNT_W  number of strobe-high cycles at the start of each frame.
- start  in  1  level; begin framing when IDLE.
- stop  in  1  level; finish the current frame, then go idle.
- req  in  NREQ  frame requests, one bit per requester.
- gnt  out  NREQ  one-hot owner of the current frame, or all zero; held for the whole frame.
- strb  out  1  frame strobe.
- frame_start  out  1  one-cycle pulse in the first cycle of each frame.
- busy  out  1  high in RUN and DRAIN.

## Operation
- Reset values: state IDLE, cnt 0, strb 0, frame_start 0, gnt 0, busy 0, round-robin pointer 0, pending config = DEF_PERIOD/DEF_WIDTH.
- Config registers:
  - `cfg_we` updates the pending registers at any time.
  - The active registers copy the pending registers only at a frame boundary: the start edge or a wrap edge.
  - A frame never changes shape mid-frame.
- States: IDLE, RUN, DRAIN.
- IDLE:
  - `start` moves to RUN.
  - On that edge: cnt←0, config latched, arbitration performed, frame_start←1.
- RUN:
  - cnt increments each cycle.
  - When cnt == period−1, cnt wraps to 0 and the next frame begins (config latch, arbitration, frame_start pulse).
  - `stop` sampled high moves to DRAIN.
  - `stop` and `start` high together: stop wins. `start` is ignored outside IDLE.
- DRAIN:
  - cnt keeps counting to period−1.
  - On the wrap edge: move to IDLE, strb←0, gnt←0, no new frame.
  - `start` is ignored in DRAIN.
- Strobe: strb is high in frame cycles 0..width−1.
  - width = 0: strb never rises.
  - width ≥ period: strb stays high for the whole frame, with no low gap between consecutive frames.
- Arbitration:
  - Round-robin over `req` sampled on the boundary edge, searching from the pointer upward with wrap.
  - The winner's gnt bit is set for the whole frame; the pointer moves to winner+1 mod NREQ.
  - No req bit set: gnt = 0 for that frame, the frame still runs, the pointer is unchanged.
  - req changes mid-frame are ignored.
- Arithmetic: period 0 means a count of 2^CNT_W, i.e. wrap at all-ones. Comparisons are unsigned, CNT_W bits.
- Reset asserted mid-frame clears everything immediately and asynchronously; framing resumes only after a new `start`.

## Timing
- All outputs are registered; no combinational path from input to output.
- Start latency: `start` sampled at edge k gives frame_start=1, strb=(width≠0), gnt and busy valid in the cycle after edge k.
- The frame is exactly `period` cycles, from frame_start to the next frame_start.
- Stop latency: stop sampled in frame cycle j leaves (period−1−j) more cycles; strb/gnt/busy clear at the wrap edge.
- `cfg_we` on the same edge as a boundary: the new value is written to pending only, and applies from the following boundary.

## Structure
- Package `frame_pkg`:
  - state enum {IDLE, RUN, DRAIN};
  - localparam helpers for the "0 = 2^CNT_W" period decode.
- Sub-module `rr_arbiter`:
  - inputs: req, ptr, enable;
  - outputs: one-hot grant, next ptr;
  - NREQ parameter;
  - purely combinational, with the pointer register held in the parent.

## Test plan
- Defaults (period 256, width 8): start pulse at cycle 10 → frame_start at 11, 267, 523; strb high for cycles 11–18; busy high from 11.
- cfg period=5, width=2, req=4'b1111, start held → strb pattern 11000 repeating; gnt sequence 0001, 0010, 0100, 1000, 0001.
- req=4'b0000 for one frame, then 4'b0100 → gnt=0 for that frame while strb still pulses, then gnt=0100; pointer unchanged across the empty frame.
- Mid-frame write width=4 while running with width=2 → current frame keeps 2 high cycles, the next frame has 4.
- Edge widths with period=6: width=0 gives strb always 0; width=6 and width=9 give strb continuously 1.
- Edge periods: period=1 gives frame_start high every cycle; period=0 gives a 256-cycle frame.
- stop at frame cycle 2 of 6 → 3 more cycles, then busy/strb/gnt drop. rst_n pulsed mid-frame → all outputs 0 asynchronously; no frame restarts without a new start.
